i2cm_arb: RTL and testbench

- Two-requester arbiter that shares one lsc_i2cm master between a boot-time config sequencer (port 0) and a runtime register-access client (port 1, e.g. brightness/exposure tuning).
- Latches the winning request, issues a single run pulse to the master, tracks running/done, and returns completion and read data to the owner.
- Sits between the sensor config/control logic and the lsc_i2cm instance in the camera front-end.

---
 rtl/i2cm_arb.sv | 182 ++++++++++++++++++
 tb/tb_i2cm_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cm_arb.sv
// Shares one lsc_i2cm master between the boot config sequencer (port 0) and runtime register client (port 1).
// Optional watchdog abort is compiled in with `define I2CM_ARB_TIMEOUT_EN.
module i2cm_arb #(
    parameter int          FIXED_PRIO = 0,
    parameter logic [15:0] TO_CYCLES  = 16'd60000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [6:0] dev0,
    input  logic [6:0] dev1,
    input  logic [7:0] ofs0,
    input  logic [7:0] ofs1,
    input  logic [7:0] wd0,
    input  logic [7:0] wd1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       m_run,
    output logic       m_rw,
    output logic [6:0] m_dev,
    output logic [7:0] m_ofs,
    output logic [7:0] m_wd,
    input  logic       m_running,
    input  logic       m_done,
    input  logic [7:0] m_rd_data
);
    typedef enum logic [2:0] {IDLE, START, ARM, BUSY, FIN} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d, last_q, last_d;
    logic       ack0_q, ack0_d, ack1_q, ack1_d;
    logic       done0_q, done0_d, done1_q, done1_d;
    logic       busy_q, busy_d, m_run_q, m_run_d;
    logic       m_rw_q, m_rw_d;
    logic [6:0] m_dev_q, m_dev_d;
    logic [7:0] m_ofs_q, m_ofs_d, m_wd_q, m_wd_d, rd_data_q, rd_data_d;
    logic       win, hold_off;

`ifdef I2CM_ARB_TIMEOUT_EN
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    // An aborted master keeps running on its own; no new grant until it stops.
    assign hold_off = m_running;
    assign err      = err_q;
`else
    logic unused_to;
    assign unused_to = ^TO_CYCLES;
    assign hold_off  = 1'b0;
    assign err       = 1'b0;
`endif

    // last_q = 1 after reset, so port 0 wins the first round-robin tie.
    assign win = (req0 && req1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_q) : ~req0;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        m_run_d   = 1'b0;
        m_rw_d    = m_rw_q;
        m_dev_d   = m_dev_q;
        m_ofs_d   = m_ofs_q;
        m_wd_d    = m_wd_q;
        rd_data_d = rd_data_q;
`ifdef I2CM_ARB_TIMEOUT_EN
        err_d     = 1'b0;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: if ((req0 || req1) && !hold_off) begin
                state_d = START;
                owner_d = win;
                ack0_d  = ~win;
                ack1_d  = win;
                m_run_d = 1'b1;
                m_rw_d  = win ? rw1  : rw0;
                m_dev_d = win ? dev1 : dev0;
                m_ofs_d = win ? ofs1 : ofs0;
                m_wd_d  = win ? wd1  : wd0;
            end
            START: begin
                state_d = ARM;
`ifdef I2CM_ARB_TIMEOUT_EN
                cnt_d   = 16'd0;
`endif
            end
            // A very fast master may finish before running is ever seen.
            ARM, BUSY: if (m_done) begin
                state_d = FIN;
                done0_d = ~owner_q;
                done1_d = owner_q;
                if (m_rw_q) rd_data_d = m_rd_data;
            end
`ifdef I2CM_ARB_TIMEOUT_EN
            else if (cnt_q == TO_CYCLES - 16'd1) begin
                state_d = FIN;
                done0_d = ~owner_q;
                done1_d = owner_q;
                err_d   = 1'b1;
            end
`endif
            else begin
                if (state_q == ARM && m_running) state_d = BUSY;
`ifdef I2CM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
            end
            FIN: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
            m_run_q   <= 1'b0;
            m_rw_q    <= 1'b0;
            m_dev_q   <= 7'd0;
            m_ofs_q   <= 8'd0;
            m_wd_q    <= 8'd0;
            rd_data_q <= 8'd0;
`ifdef I2CM_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
            m_run_q   <= m_run_d;
            m_rw_q    <= m_rw_d;
            m_dev_q   <= m_dev_d;
            m_ofs_q   <= m_ofs_d;
            m_wd_q    <= m_wd_d;
            rd_data_q <= rd_data_d;
`ifdef I2CM_ARB_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign busy    = busy_q;
    assign m_run   = m_run_q;
    assign m_rw    = m_rw_q;
    assign m_dev   = m_dev_q;
    assign m_ofs   = m_ofs_q;
    assign m_wd    = m_wd_q;
    assign rd_data = rd_data_q;
endmodule

// File: tb/tb_i2cm_arb.sv
// Randomized bench for i2cm_arb: a master model plus a transaction-phase reference checked every cycle.
// Directed sections cover write, read hold, tie order, withdraw, reset, fast master and (optionally) timeout.
module tb_i2cm_arb;
    localparam int FIXED_PRIO = 0;
    localparam int TO = 100;
`ifdef I2CM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       req0, req1, rw0, rw1;
    logic [6:0] dev0, dev1, m_dev;
    logic [7:0] ofs0, ofs1, wd0, wd1, rd_data, m_ofs, m_wd, m_rd_data;
    logic       ack0, ack1, done0, done1, err, busy, m_run, m_rw, m_running, m_done;

    int   n_chk = 0, n_fail = 0;
    int   mode = 0;            // 0 normal master, 1 fast (done without running), 2 hang
    bit   hang_release = 1'b0;
    bit   rd_fix = 1'b0;
    logic [7:0] rd_fix_val = 8'h00;

    always #5 clk = ~clk;

    i2cm_arb #(.FIXED_PRIO(FIXED_PRIO), .TO_CYCLES(16'(TO))) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .dev0(dev0), .dev1(dev1), .ofs0(ofs0), .ofs1(ofs1), .wd0(wd0), .wd1(wd1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .err(err),
        .rd_data(rd_data), .busy(busy), .m_run(m_run), .m_rw(m_rw),
        .m_dev(m_dev), .m_ofs(m_ofs), .m_wd(m_wd),
        .m_running(m_running), .m_done(m_done), .m_rd_data(m_rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Master model: reacts to m_run one cycle later.
    initial begin
        m_running = 1'b0; m_done = 1'b0; m_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (m_run && resetn) begin
                int md;
                md = mode;
                @(negedge clk);
                if (md == 1) begin
                    m_rd_data = rd_fix ? rd_fix_val : 8'($urandom);
                    m_done = 1'b1;
                    @(negedge clk);
                    m_done = 1'b0;
                end else begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    m_running = 1'b1;
                    if (md == 2) begin
                        wait (hang_release);
                        m_running = 1'b0;
                    end else begin
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                        m_rd_data = rd_fix ? rd_fix_val : 8'($urandom);
                        m_done = 1'b1;
                        m_running = 1'b0;
                        @(negedge clk);
                        m_done = 1'b0;
                    end
                end
            end
        end
    end

    // Reference: a transaction moves IDLE -> START -> WAIT (arm/busy merged) -> FIN.
    typedef enum int {P_IDLE, P_START, P_WAIT, P_FIN} ph_t;
    initial begin
        ph_t ph;
        int own, last, to_cnt;
        logic e_rw, e_err, st, fn;
        logic [6:0] e_dev;
        logic [7:0] e_ofs, e_wd, e_rd;
        ph = P_IDLE; own = 0; last = 1; to_cnt = 0;
        e_rw = 0; e_err = 0; e_dev = 0; e_ofs = 0; e_wd = 0; e_rd = 0;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                ph = P_IDLE; own = 0; last = 1; to_cnt = 0;
                e_rw = 0; e_err = 0; e_dev = 0; e_ofs = 0; e_wd = 0; e_rd = 0;
            end else begin
                case (ph)
                    P_IDLE: if ((req0 || req1) && !(TO_EN && m_running)) begin
                        if (req0 && req1) own = (FIXED_PRIO != 0) ? 0 : (last == 0 ? 1 : 0);
                        else              own = req0 ? 0 : 1;
                        if (own == 0) begin e_rw = rw0; e_dev = dev0; e_ofs = ofs0; e_wd = wd0; end
                        else          begin e_rw = rw1; e_dev = dev1; e_ofs = ofs1; e_wd = wd1; end
                        ph = P_START;
                    end
                    P_START: begin ph = P_WAIT; to_cnt = 0; end
                    P_WAIT: begin
                        if (m_done) begin
                            ph = P_FIN; e_err = 0;
                            if (e_rw) e_rd = m_rd_data;
                        end else if (TO_EN && to_cnt == TO - 1) begin
                            ph = P_FIN; e_err = 1;
                        end else to_cnt++;
                    end
                    default: begin ph = P_IDLE; last = own; end
                endcase
            end
            #1;
            st = (ph == P_START);
            fn = (ph == P_FIN);
            chk("ack0",  32'(ack0),  32'(st && own == 0));
            chk("ack1",  32'(ack1),  32'(st && own == 1));
            chk("m_run", 32'(m_run), 32'(st));
            chk("done0", 32'(done0), 32'(fn && own == 0));
            chk("done1", 32'(done1), 32'(fn && own == 1));
            chk("err",   32'(err),   32'(fn && e_err));
            chk("busy",  32'(busy),  32'(ph != P_IDLE));
            chk("m_rw",  32'(m_rw),  32'(e_rw));
            chk("m_dev", 32'(m_dev), 32'(e_dev));
            chk("m_ofs", 32'(m_ofs), 32'(e_ofs));
            chk("m_wd",  32'(m_wd),  32'(e_wd));
            chk("rd_data", 32'(rd_data), 32'(e_rd));
        end
    end

    task automatic rand_fields(input int p);
        if (p == 0) begin rw0 = 1'($urandom); dev0 = 7'($urandom); ofs0 = 8'($urandom); wd0 = 8'($urandom); end
        else        begin rw1 = 1'($urandom); dev1 = 7'($urandom); ofs1 = 8'($urandom); wd1 = 8'($urandom); end
    endtask

    task automatic issue(input int p, input logic rw, input logic [6:0] dev, input logic [7:0] ofs,
                         input logic [7:0] wd, output int n);
        if (p == 0) begin rw0 = rw; dev0 = dev; ofs0 = ofs; wd0 = wd; req0 = 1'b1; end
        else        begin rw1 = rw; dev1 = dev; ofs1 = ofs; wd1 = wd; req1 = 1'b1; end
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if ((p == 0) ? ack0 : ack1) break;
        end
        chk("issue_ack", 32'((p == 0) ? ack0 : ack1), 32'd1);
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic wait_done(input int p);
        int n;
        n = 0;
        while (!((p == 0) ? done0 : done1) && n < 300) begin @(negedge clk); n++; end
        chk("done_seen", 32'((p == 0) ? done0 : done1), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        chk("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n, k;
        int order [4];
        resetn = 1'b0;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; dev0 = 0; dev1 = 0;
        ofs0 = 0; ofs1 = 0; wd0 = 0; wd1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // single write from port 0
        issue(0, 1'b0, 7'h3c, 8'h12, 8'h80, n);
        chk("wr_ack_lat", 32'(n), 32'd1);
        chk("wr_m_run", 32'(m_run), 32'd1);
        chk("wr_m_dev", 32'(m_dev), 32'h3c);
        chk("wr_m_ofs", 32'(m_ofs), 32'h12);
        chk("wr_m_wd",  32'(m_wd),  32'h80);
        wait_done(0);
        chk("wr_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("wr_busy_fall", 32'(busy), 32'd0);

        // read from port 1, then a write must not disturb rd_data
        rd_fix = 1'b1; rd_fix_val = 8'h76;
        issue(1, 1'b1, 7'h21, 8'h0a, 8'h00, n);
        wait_done(1);
        chk("rd_val", 32'(rd_data), 32'h76);
        rd_fix = 1'b0;
        wait_idle();
        issue(1, 1'b0, 7'h21, 8'h0b, 8'h55, n);
        wait_done(1);
        wait_idle();
        chk("rd_hold", 32'(rd_data), 32'h76);

        // tie: both held for four grants
        rand_fields(0); rand_fields(1);
        req0 = 1'b1; req1 = 1'b1;
        k = 0; n = 0;
        while (k < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) begin
                order[k] = ack1 ? 1 : 0;
                k++;
                if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie_cnt", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) chk("tie_order", 32'(order[i]), (FIXED_PRIO != 0) ? 32'd0 : 32'(i % 2));
        wait_idle();

        // req1 withdrawn while port 0 is in flight
        issue(0, 1'b1, 7'h10, 8'h20, 8'h30, n);
        n = 0;
        while (!m_running && n < 20) begin @(negedge clk); n++; end
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        k = 0;
        repeat (20) begin @(negedge clk); if (ack1) k++; end
        chk("withdraw_no_ack1", 32'(k), 32'd0);
        wait_idle();

        // reset in the middle of a transaction
        mode = 2;
        issue(0, 1'b0, 7'h11, 8'h22, 8'h33, n);
        n = 0;
        while (!m_running && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        resetn = 1'b0; hang_release = 1'b1; mode = 0;
        #1;
        chk("rst_mid_busy",  32'(busy),  32'd0);
        chk("rst_mid_m_dev", 32'(m_dev), 32'd0);
        @(negedge clk);
        hang_release = 1'b0;
        k = 0;
        repeat (2) begin @(negedge clk); if (done0) k++; end
        chk("rst_no_done0", 32'(k), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 7'h44, 8'h55, 8'h66, n);
        chk("post_rst_ack_lat", 32'(n), 32'd1);
        wait_done(0);
        wait_idle();

        // fast master: done while still arming
        mode = 1;
        for (int i = 0; i < 4; i++) begin
            int p;
            p = i % 2;
            issue(p, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), n);
            wait_done(p);
            wait_idle();
        end
        mode = 0;

`ifdef I2CM_ARB_TIMEOUT_EN
        mode = 2;
        issue(0, 1'b1, 7'h3c, 8'h01, 8'h00, n);
        n = 0;
        while (!done0 && n < 300) begin @(negedge clk); n++; end
        chk("to_latency", 32'(n), 32'd101);
        chk("to_err", 32'(err), 32'd1);
        req0 = 1'b1;
        k = 0;
        repeat (10) begin @(negedge clk); if (ack0) k++; end
        chk("to_holdoff", 32'(k), 32'd0);
        mode = 0; hang_release = 1'b1;
        issue(0, 1'b0, 7'h3c, 8'h02, 8'h03, n);
        hang_release = 1'b0;
        chk("to_regrant_lat", 32'(n), 32'd1);
        wait_done(0);
        wait_idle();
`endif

        // random traffic
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (req0 && ack0) begin if ($urandom_range(0, 1) == 0) req0 = 1'b0; end
            else if (!req0 && $urandom_range(0, 3) == 0) begin rand_fields(0); req0 = 1'b1; end
            else if (req0 && $urandom_range(0, 15) == 0) req0 = 1'b0;
            else if (req0 && $urandom_range(0, 7) == 0) rand_fields(0);
            if (req1 && ack1) begin if ($urandom_range(0, 1) == 0) req1 = 1'b0; end
            else if (!req1 && $urandom_range(0, 3) == 0) begin rand_fields(1); req1 = 1'b1; end
            else if (req1 && $urandom_range(0, 15) == 0) req1 = 1'b0;
            else if (req1 && $urandom_range(0, 7) == 0) rand_fields(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
